// File: rtl/spectrum_video_fetch.sv
// ZX Spectrum screen fetch, attribute colouring and border for an RGB565 LCD.
// Optional `SCALE2X_EN doubles every Spectrum pixel to 2x2 (512x384 window).
module spectrum_video_fetch #(
  parameter logic [10:0] H_START = 11'd144,
  parameter logic [9:0]  V_START = 10'd48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic [10:0] hcnt,
  input  logic [9:0]  vcnt,
  input  logic        de,
  input  logic [2:0]  border,
  output logic [12:0] ram_addr,
  output logic        ram_re,
  input  logic [7:0]  ram_pix,
  input  logic [7:0]  ram_attr,
  output logic [4:0]  lcd_r,
  output logic [5:0]  lcd_g,
  output logic [4:0]  lcd_b,
  output logic        frame_int
);

`ifdef SCALE2X_EN
  localparam int SH = 1;
`else
  localparam int SH = 0;
`endif

  localparam logic [10:0] WIN_W  = 11'(256 << SH);
  localparam logic [10:0] WIN_H  = 11'(192 << SH);
  localparam logic [10:0] CELL_M = 11'((8 << SH) - 1);
  localparam logic [10:0] FET_PH = 11'((8 << SH) - 2);
  localparam logic [10:0] F_OFF  = 11'(2 << SH);
  localparam int          COL_SH = 3 + SH;

  logic [7:0]  shift_q, shift_d;
  logic [7:0]  attr_q, attr_d;
  logic [4:0]  flash_q, flash_d;
  logic [2:0]  border_q, border_d;
  logic        re_q, re_d;
  logic [15:0] rgb_q, rgb_d;

  logic [10:0] wx, wy, phase, fr, colv, yv;
  logic        hwin, vwin, fetch, load, sh_tick, frame_start;
  logic [4:0]  col;
  logic [7:0]  y;
  logic        on;
  logic [2:0]  idx, bcol;
  logic [4:0]  lvl_rb;
  logic [5:0]  lvl_g;
  logic [15:0] pix_rgb, brd_rgb;
  logic        unused_bits;

  assign wx    = hcnt - H_START;
  assign wy    = {1'b0, vcnt} - {1'b0, V_START};
  assign hwin  = wx < WIN_W;
  assign vwin  = wy < WIN_H;
  assign phase = wx & CELL_M;
  assign fr    = wx + F_OFF;

  // Next cell starts two ticks after the fetch slot.
  assign colv  = (wx + 11'd2) >> COL_SH;
  assign yv    = wy >> SH;
  assign col   = colv[4:0];
  assign y     = yv[7:0];
  assign unused_bits = ^{colv[10:5], yv[10:8]};

  assign fetch = vwin & (fr < WIN_W) & (phase == FET_PH);
  assign ram_re = fetch & pix_ce & ~reset;
  assign ram_addr = ram_re ? {y[7:6], y[2:0], y[5:3], col} : 13'd0;

  assign frame_start = (hcnt == 11'd0) & (vcnt == 10'd0);
  assign frame_int   = frame_start & pix_ce & ~reset;

  // Capture only data that was actually requested on the previous tick.
  assign load    = pix_ce & re_q & (phase == CELL_M);
  assign sh_tick = (SH == 0) ? 1'b1 : wx[0];

  assign on     = shift_q[7] ^ (attr_q[7] & flash_q[4]);
  assign idx    = on ? attr_q[2:0] : attr_q[5:3];
  assign lvl_rb = attr_q[6] ? 5'h1F : 5'h17;
  assign lvl_g  = attr_q[6] ? 6'h3F : 6'h2F;
  assign pix_rgb = {idx[1] ? lvl_rb : 5'h0,
                    idx[2] ? lvl_g  : 6'h0,
                    idx[0] ? lvl_rb : 5'h0};

  assign bcol    = (hcnt == 11'd0) ? border : border_q;
  assign brd_rgb = {bcol[1] ? 5'h17 : 5'h0,
                    bcol[2] ? 6'h2F : 6'h0,
                    bcol[0] ? 5'h17 : 5'h0};

  // Next-state: fetch tracking, shifter, flash counter and colour output.
  always_comb begin
    shift_d  = shift_q;
    attr_d   = attr_q;
    flash_d  = flash_q;
    border_d = border_q;
    re_d     = re_q;
    rgb_d    = rgb_q;
    if (pix_ce) begin
      re_d = ram_re;
      if (hcnt == 11'd0) border_d = border;
      if (frame_start) flash_d = flash_q + 5'd1;
      if (load) begin
        shift_d = ram_pix;
        attr_d  = ram_attr;
      end else if (sh_tick) begin
        shift_d = {shift_q[6:0], 1'b0};
      end
      if (!de) rgb_d = 16'h0;
      else if (hwin && vwin) rgb_d = pix_rgb;
      else rgb_d = brd_rgb;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q  <= 8'h0;
      attr_q   <= 8'h0;
      flash_q  <= 5'h0;
      border_q <= 3'h0;
      re_q     <= 1'b0;
      rgb_q    <= 16'h0;
    end else begin
      shift_q  <= shift_d;
      attr_q   <= attr_d;
      flash_q  <= flash_d;
      border_q <= border_d;
      re_q     <= re_d;
      rgb_q    <= rgb_d;
    end
  end

  assign lcd_r = rgb_q[15:11];
  assign lcd_g = rgb_q[10:5];
  assign lcd_b = rgb_q[4:0];

endmodule

// File: tb/tb_spectrum_video_fetch.sv
// Directed bench for spectrum_video_fetch with a registered screen RAM model.
// Honours `SCALE2X_EN through the scale factor S.
module tb_spectrum_video_fetch;

`ifdef SCALE2X_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int HS    = 144;
  localparam int VS    = 48;
  localparam int H_END = HS + 256 * S + 8;

  localparam logic [15:0] WHT_B = 16'hFFFF;
  localparam logic [15:0] RED_N = 16'hB800;
  localparam logic [15:0] YEL_N = 16'hBDE0;
  localparam logic [15:0] WHT_N = 16'hBDF7;

  logic        clk, reset, pix_ce, de;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic [2:0]  border;
  logic [12:0] ram_addr;
  logic        ram_re, frame_int;
  logic [7:0]  ram_pix, ram_attr;
  logic [4:0]  lcd_r, lcd_b;
  logic [5:0]  lcd_g;

  logic [7:0]  pix_mem [8192];
  logic [7:0]  attr_mem[1024];
  logic        re_log  [1024];
  logic [12:0] addr_log[1024];
  logic [15:0] pix_log [1024];

  int n_chk, n_err, nf;
  logic [15:0] hold_rgb;

  spectrum_video_fetch dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .hcnt(hcnt), .vcnt(vcnt), .de(de), .border(border),
    .ram_addr(ram_addr), .ram_re(ram_re),
    .ram_pix(ram_pix), .ram_attr(ram_attr),
    .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
    .frame_int(frame_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_re) begin
      ram_pix  <= pix_mem[ram_addr];
      ram_attr <= attr_mem[{ram_addr[12:11], ram_addr[7:0]}];
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int h, input int v, input logic d);
    @(posedge clk); #1;
    hcnt = 11'(h);
    vcnt = 10'(v);
    de   = d;
  endtask

  task automatic scan_line(input int v, input logic d,
                           input logic [2:0] bl, input int rst_h);
    for (int h = 0; h <= H_END; h++) begin
      drive(h, v, d);
      reset  = (h == rst_h);
      border = (h == 0) ? bl : ~bl;
      #1;
      re_log[h]   = ram_re;
      addr_log[h] = ram_addr;
      if (h > 0) pix_log[h-1] = {lcd_r, lcd_g, lcd_b};
    end
  endtask

  function automatic int fetches();
    int c = 0;
    for (int h = 0; h <= H_END; h++) if (re_log[h]) c++;
    return c;
  endfunction

  function automatic int px(input int x);
    return HS + x * S;
  endfunction

  task automatic frames(input int n);
    nf = 0;
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 1'b0); #1;
      if (frame_int) nf++;
      drive(1, 0, 1'b0); #1;
      if (frame_int) nf++;
    end
    check("frame_int_count", nf, n);
  endtask

  initial begin
    logic [7:0] a5;
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 8192; i++) pix_mem[i] = 8'h0;
    for (int i = 0; i < 1024; i++) attr_mem[i] = 8'h0;
    pix_mem[13'h0B45] = 8'hA5; attr_mem[10'h145] = 8'h47;
    pix_mem[13'h0B5F] = 8'h01; attr_mem[10'h15F] = 8'h47;
    pix_mem[13'h0000] = 8'hF0; attr_mem[10'h000] = 8'h86;
    pix_mem[13'h0102] = 8'h80; attr_mem[10'h002] = 8'h07;
    ram_pix = 8'h0; ram_attr = 8'h0;
    a5 = 8'hA5;

    reset = 1'b1; pix_ce = 1'b1; de = 1'b1; border = 3'b0;
    hcnt = 11'(HS - 2 * S); vcnt = 10'(VS);
    repeat (2) @(posedge clk);
    #2;
    check("rst_ram_re", ram_re, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_lcd", {lcd_r, lcd_g, lcd_b}, 0);
    check("rst_frame_int", frame_int, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    scan_line(VS + 8'h53 * S, 1'b1, 3'b010, -1);
    check("addr_col0", addr_log[HS - 2 * S], 13'h0B40);
    check("re_col5", re_log[px(40) - 2], 1);
    check("addr_col5", addr_log[px(40) - 2], 13'h0B45);
    check("fetch_count", fetches(), 32);
    check("no_col32", re_log[px(256) - 2], 0);
    for (int k = 0; k < 8; k++)
      check($sformatf("a5_px%0d", k), pix_log[px(40 + k)],
            a5[7 - k] ? WHT_B : 16'h0);
    check("px48_black", pix_log[px(48)], 0);
    check("px254", pix_log[px(254)], 0);
    check("px255", pix_log[px(255)], WHT_B);
    check("border_left", pix_log[HS - 1], RED_N);
    check("border_right", pix_log[px(256)], RED_N);

    drive(HS - 2 * S, VS + 8'h53 * S, 1'b0);
    pix_ce = 1'b0;
    #1;
    check("ce_low_re", ram_re, 0);
    @(posedge clk); #2;
    check("ce_low_hold", {lcd_r, lcd_g, lcd_b}, RED_N);
    pix_ce = 1'b1;

    scan_line(VS + 8'h53 * S, 1'b0, 3'b010, -1);
    check("de0_window", pix_log[px(40)], 0);
    check("de0_border", pix_log[HS - 1], 0);

    scan_line(VS - 1, 1'b1, 3'b010, -1);
    check("vout_fetches", fetches(), 0);
    check("vout_border", pix_log[px(40)], RED_N);

    scan_line(VS, 1'b1, 3'b000, -1);
    check("flash0_ink", pix_log[px(0)], YEL_N);
    check("flash0_paper", pix_log[px(4)], 0);
    frames(16);
    scan_line(VS, 1'b1, 3'b000, -1);
    check("flash16_ink", pix_log[px(0)], 0);
    check("flash16_paper", pix_log[px(4)], YEL_N);
    frames(16);
    scan_line(VS, 1'b1, 3'b000, -1);
    check("flash32_ink", pix_log[px(0)], YEL_N);
    check("flash32_paper", pix_log[px(4)], 0);

    for (int ln = 0; ln < 2; ln++) begin
      scan_line(VS + S + ln * (S - 1), 1'b1, 3'b000, -1);
      check($sformatf("sc%0d_ink0", ln), pix_log[px(16)], WHT_N);
      check($sformatf("sc%0d_inkS", ln), pix_log[px(16) + S - 1], WHT_N);
      check($sformatf("sc%0d_paper", ln), pix_log[px(16) + S], 0);
      check($sformatf("sc%0d_end", ln), pix_log[px(16) + 8 * S - 1], 0);
    end

    scan_line(VS + 8'h53 * S, 1'b1, 3'b010, px(40) - 2);
    check("rst_mid_re", re_log[px(40) - 2], 0);
    check("rst_mid_addr", addr_log[px(40) - 2], 0);
    check("rst_mid_px40", pix_log[px(40)], 0);
    check("rst_mid_px42", pix_log[px(42)], 0);
    check("rst_mid_refetch", re_log[px(48) - 2], 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
